// File: rtl/ram_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_upload_reader
//  Purpose  : Streams a window of game work RAM to hps_io through ioctl_din
//             while an upload runs on ioctl index INDEX. The block can request
//             the upload itself (save_trigger). It keeps the CPU paused while
//             RAM is read, and services each ioctl_rd with one RAM read.
//  Ports    : clk_sys, reset          - clock, synchronous active-high reset
//             save_trigger            - one-cycle save request
//             ioctl_upload/_index/_addr/_rd, ioctl_din, ioctl_upload_req
//                                     - hps_io upload handshake
//             pause_req, paused       - pause block handshake
//             ram_addr, ram_rd, ram_dout - single-port RAM read port
//             busy, overrun, timeout  - status (overrun/timeout sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_upload_reader #(
    parameter int          ADDR_W    = 10,
    parameter int          LEN       = 1024,
    parameter logic [7:0]  INDEX     = 8'd4,
    parameter int          TIMEOUT_W = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              save_trigger,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_upload_req,
    output logic              pause_req,
    input  logic              paused,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ARM     = 3'd2,
        S_SERVE   = 3'd3,
        S_READ    = 3'd4,
        S_CAPTURE = 3'd5
    } state_t;

    // Full 25-bit compare so out-of-window addresses never alias into RAM.
    localparam logic [24:0]          LEN_C   = 25'(LEN);
    // Leaving REQ on the edge where the counter reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] CNT_END = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t              state_q, state_d;
    logic [24:0]         addr_q, addr_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic                to_q, to_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [7:0]          din_q, din_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                rrd_q, rrd_d;
    logic                req_q, pause_q, busy_q;

    logic match;
    assign match = ioctl_upload && (ioctl_index == INDEX);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        raddr_d = raddr_q;
        rrd_d   = 1'b0;

        // Strobes are accepted in every upload state; those that cannot be
        // serviced right away are parked as pending. A newer strobe replaces
        // an unserviced one and flags the loss.
        if (state_q inside {S_ARM, S_SERVE, S_READ, S_CAPTURE} && ioctl_rd) begin
            addr_d = ioctl_addr;
            pend_d = 1'b1;
            if (pend_q) ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (save_trigger) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    ovr_d   = 1'b0;
                end else if (match) begin
                    state_d = S_ARM;
                end
            end
            S_REQ: begin
                if (match) begin
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                    if (cnt_q == CNT_END) begin
                        state_d = S_IDLE;
                        to_d    = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else if (paused) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else if (!paused) begin
                    // CPU resumed under us: hold reads until it halts again.
                    state_d = S_ARM;
                end else if (pend_q && !ioctl_rd) begin
                    pend_d = 1'b0;
                    if (addr_q < LEN_C) begin
                        raddr_d = addr_q[ADDR_W-1:0];
                        rrd_d   = 1'b1;
                        state_d = S_READ;
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                din_d   = ram_dout;
                state_d = ioctl_upload ? S_SERVE : S_IDLE;
                if (!ioctl_upload) pend_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            raddr_q <= '0;
            rrd_q   <= 1'b0;
            req_q   <= 1'b0;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            raddr_q <= raddr_d;
            rrd_q   <= rrd_d;
            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            req_q   <= (state_d == S_REQ);
            pause_q <= state_d inside {S_ARM, S_SERVE, S_READ, S_CAPTURE};
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign ioctl_din        = din_q;
    assign ioctl_upload_req = req_q;
    assign pause_req        = pause_q;
    assign ram_addr         = raddr_q;
    assign ram_rd           = rrd_q;
    assign busy             = busy_q;
    assign overrun          = ovr_q;
    assign timeout          = to_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_upload_reader
//  Purpose  : Self-checking bench for ram_upload_reader with a behavioural
//             single-port RAM and an expected-byte scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        save_trigger;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        pause_req;
    logic        paused;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int n_total = 0;
    int n_bad   = 0;
    int rd_count = 0;

    logic [7:0] mem [0:1023];
    logic [7:0] exp_q [$];

    always #5 clk_sys = ~clk_sys;

    ram_upload_reader #(
        .ADDR_W    (10),
        .LEN       (1024),
        .INDEX     (8'd4),
        .TIMEOUT_W (4)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .save_trigger     (save_trigger),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_addr       (ioctl_addr),
        .ioctl_rd         (ioctl_rd),
        .ioctl_din        (ioctl_din),
        .ioctl_upload_req (ioctl_upload_req),
        .pause_req        (pause_req),
        .paused           (paused),
        .ram_addr         (ram_addr),
        .ram_rd           (ram_rd),
        .ram_dout         (ram_dout),
        .busy             (busy),
        .overrun          (overrun),
        .timeout          (timeout)
    );

    // RAM: data valid only for the single cycle after ram_rd.
    always @(posedge clk_sys) begin
        if (ram_rd) ram_dout <= mem[ram_addr];
        else        ram_dout <= 8'h00;
    end

    always @(posedge clk_sys) if (ram_rd) rd_count <= rd_count + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    // One ioctl_rd while in SERVE; byte must appear on the 3rd edge.
    task automatic rd_txn(input logic [24:0] a, input string tag);
        logic       in_rng;
        logic [7:0] prev;
        int         rc;
        in_rng = (a < 25'd1024);
        exp_q.push_back(in_rng ? mem[a[9:0]] : 8'hFF);
        rc   = rd_count;
        prev = ioctl_din;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        if (in_rng) begin
            chk({tag, "_ram_rd"}, 32'(ram_rd), 32'd1);
            chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(a[9:0]));
        end
        tick();
        if (in_rng && exp_q[0] != prev)
            chk({tag, "_din_early"}, 32'(ioctl_din), 32'(prev));
        tick();
        chk({tag, "_din"}, 32'(ioctl_din), 32'(exp_q.pop_front()));
        chk({tag, "_nreads"}, 32'(rd_count - rc), in_rng ? 32'd1 : 32'd0);
        tick(6);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[5]    = 8'h3C;
        mem[7]    = 8'h11;
        mem[9]    = 8'h66;
        mem[1023] = 8'hA5;

        reset = 1'b1; save_trigger = 1'b0; ioctl_upload = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_rd = 1'b0; paused = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();
        chk("rst_din",     32'(ioctl_din), 32'h0);
        chk("rst_req",     32'(ioctl_upload_req), 32'h0);
        chk("rst_pause",   32'(pause_req), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_flags",   {30'd0, overrun, timeout}, 32'h0);
        chk("rst_ram_rd",  32'(ram_rd), 32'h0);

        // Save request, then HPS answers on our index.
        save_trigger = 1'b1; tick(); save_trigger = 1'b0;
        chk("save_req",  32'(ioctl_upload_req), 32'h1);
        chk("save_busy", 32'(busy), 32'h1);
        ioctl_upload = 1'b1; ioctl_index = 8'd4;
        tick();
        chk("arm_req",   32'(ioctl_upload_req), 32'h0);
        chk("arm_pause", 32'(pause_req), 32'h1);
        rc = rd_count;
        tick(10);
        chk("arm_no_rd", 32'(rd_count - rc), 32'h0);
        chk("arm_hold",  32'(pause_req), 32'h1);

        paused = 1'b1;
        tick();
        rd_txn(25'd5, "rd5");
        rd_txn(25'd1023, "rd1023");
        rd_txn(25'd1024, "rd1024");
        rd_txn(25'h100_0005, "rd_hi");

        // Reads queued while the CPU is not halted; the later one wins.
        paused = 1'b0;
        tick();
        chk("hold_pause", 32'(pause_req), 32'h1);
        ioctl_addr = 25'd7; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        tick(2);
        ioctl_addr = 25'd9; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        tick();
        chk("ovr_flag", 32'(overrun), 32'h1);
        rc = rd_count;
        exp_q.push_back(mem[9]);
        paused = 1'b1;
        tick(2);
        chk("ovr_ram_rd",   32'(ram_rd), 32'h1);
        chk("ovr_ram_addr", 32'(ram_addr), 32'd9);
        tick(2);
        chk("ovr_din", 32'(ioctl_din), 32'(exp_q.pop_front()));
        tick(4);
        chk("ovr_nreads", 32'(rd_count - rc), 32'h1);

        // Upload ends mid-SERVE.
        ioctl_upload = 1'b0;
        tick();
        chk("drop_pause", 32'(pause_req), 32'h0);
        chk("drop_busy",  32'(busy), 32'h0);
        chk("drop_ovr_sticky", 32'(overrun), 32'h1);

        // Request that expires; an upload on another index is ignored.
        paused = 1'b0;
        save_trigger = 1'b1; tick(); save_trigger = 1'b0;
        chk("save2_ovr_clr", 32'(overrun), 32'h0);
        ioctl_upload = 1'b1; ioctl_index = 8'd3;
        n = 0;
        while (ioctl_upload_req && n < 40) begin
            n++;
            if (pause_req) chk("req_other_idx", 32'(pause_req), 32'h0);
            tick();
        end
        chk("to_cycles", 32'(n), 32'd15);
        chk("to_flag",   32'(timeout), 32'h1);
        chk("to_busy",   32'(busy), 32'h0);
        tick(2);
        chk("to_idle_other_idx", 32'(busy), 32'h0);

        // Reset while a RAM read is in flight.
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1; ioctl_index = 8'd4;
        tick();
        chk("hps_arm", 32'(pause_req), 32'h1);
        paused = 1'b1;
        tick();
        ioctl_addr = 25'd5; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        tick();
        chk("pre_rst_ram_rd", 32'(ram_rd), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_rst_pause",  32'(pause_req), 32'h0);
        chk("mid_rst_ram_rd", 32'(ram_rd), 32'h0);
        chk("mid_rst_busy",   32'(busy), 32'h0);
        chk("mid_rst_to",     32'(timeout), 32'h0);
        reset = 1'b0;
        ioctl_upload = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_upload_reader.md
Name: ram_upload_reader

Overview:
- Serves the HPS upload direction (core → HPS): streams a window of game work RAM out through ioctl_din when hps_io runs an upload on a chosen ioctl index.
- Counterpart of the download path that fills ROM/DIP/hiscore data.
- Requests the upload, holds the CPU paused while reading, and services each ioctl_rd with a single-port RAM read.
- Sits between hps_io, the pause block and a read port on game RAM.

Parameters:
- ADDR_W, 10, RAM address width.
- LEN, 1024, bytes uploaded; addresses ≥ LEN return 8'hFF.
- INDEX, 8'd4, ioctl_index this block answers.
- TIMEOUT_W, 24, width of the upload-request timeout counter.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- save_trigger  in  1  one-cycle pulse requesting a save.
- ioctl_upload  in  1  hps_io upload active.
- ioctl_index  in  8  hps_io current index.
- ioctl_addr  in  25  hps_io byte address.
- ioctl_rd  in  1  hps_io read strobe, one cycle.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_upload_req  out  1  asks HPS to start an upload.
- pause_req  out  1  to pause block; CPU must halt.
- paused  in  1  pause block confirms CPU halted.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  RAM read enable, one cycle.
- ram_dout  in  8  RAM data; valid exactly 1 cycle after ram_rd.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky: ioctl_rd arrived while a read was pending.
- timeout  out  1  sticky: request expired without an upload.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Pending flag cleared. Timeout counter 0.
- Reset mid-operation aborts immediately: pause_req and ioctl_upload_req drop on the next edge.
- "match" means ioctl_upload=1 and ioctl_index==INDEX.
- IDLE:
  - save_trigger → REQ. Clear the timeout flag and counter.
  - match (HPS-initiated) → ARM.
- REQ:
  - ioctl_upload_req=1.
  - match → ARM; upload_req drops on the same edge.
  - Counter reaches 2^TIMEOUT_W−1 → IDLE with timeout set.
  - An upload on a different index is ignored; stay in REQ.
- ARM: pause_req=1. paused=1 → SERVE.
- SERVE:
  - pause_req=1.
  - A pending read, or a new ioctl_rd, latches ioctl_addr.
  - If addr < LEN: drive ram_addr=addr[ADDR_W-1:0] and ram_rd=1 for one cycle → READ.
  - Otherwise set ioctl_din=8'hFF the next cycle and stay in SERVE.
- READ: one cycle → CAPTURE.
- CAPTURE: ioctl_din <= ram_dout → SERVE.
- Read latency: ioctl_din is updated on the 3rd rising edge after the edge that samples ioctl_rd while in SERVE. hps_io spaces strobes ≥ 8 cycles apart.
- ioctl_rd outside SERVE (ARM, READ, CAPTURE): address latched and pending set; serviced on the next SERVE cycle.
- A second ioctl_rd while pending is set: new address overwrites the old one, overrun set (sticky until reset or next save_trigger).
- ioctl_upload falling, in any of ARM/SERVE/READ/CAPTURE:
  - Finish any in-flight CAPTURE, then → IDLE.
  - pause_req drops on entry to IDLE. Pending is cleared.
- If paused drops during SERVE, further reads wait in ARM-equivalent hold (pause_req stays 1) until paused returns.
- ioctl_index changing during the upload is ignored once ARM is entered.
- save_trigger while busy: ignored.
- ioctl_din holds its last value between reads.
- Address compare is unsigned over the full 25 bits: addr 1024 with LEN=1024 returns FF. No wrap into RAM.

Test Plan:
- Reset, pulse save_trigger → ioctl_upload_req=1 next cycle, busy=1. Raise upload with index 4 → req 0, pause_req 1. Hold paused 0 for 10 cycles → no ram_rd.
- Paused=1; RAM[5]=8'h3C; ioctl_rd with addr 5 → ram_rd with ram_addr 5 one cycle later; ioctl_din=8'h3C on the 3rd edge after the strobe.
- Read addr 1023 (data 8'hA5) then addr 1024 → din A5, then FF, with no ram_rd for 1024.
- ioctl_rd at addr 7 during ARM, then a second rd at addr 9 before paused → overrun=1; after paused, exactly one ram_rd with addr 9.
- TIMEOUT_W=4, save_trigger, no upload → after 15 cycles req drops, timeout=1, busy=0. Upload on index 3 during REQ → ignored.
- Assert reset in READ → next cycle pause_req=0, ram_rd=0, busy=0. Drop ioctl_upload mid-SERVE (no reset) → IDLE, pause_req=0 next cycle.
